// File: rtl/cnn_pkg.sv
// Shared definitions for the first CNN layer: data width, pool scheduler
// states and the geometry helpers derived from image side N and kernel side M.
package cnn_pkg;

    localparam int DW = 13;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_LAST = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } pool_state_t;

    function automatic int fmap_w(input int n, input int m);
        return n - m + 1;
    endfunction

    function automatic int pool_p(input int n, input int m);
        return fmap_w(n, m) / 2;
    endfunction

    // Widths are clamped to 1 so degenerate geometries still elaborate.
    function automatic int addr_w(input int n, input int m);
        int w;
        w = fmap_w(n, m);
        return (w * w > 1) ? $clog2(w * w) : 1;
    endfunction

    function automatic int idx_w(input int n, input int m);
        int p;
        p = pool_p(n, m);
        return (p * p > 1) ? $clog2(p * p) : 1;
    endfunction

endpackage

// File: rtl/pool_sched_win_max.sv
// Running signed maximum over one pooling window: load takes the first datum,
// acc replaces the held value only when the new datum is strictly greater.
module win_max
    import cnn_pkg::*;
#(
    parameter int DW = cnn_pkg::DW
) (
    input  logic                 clk,
    input  logic                 load,
    input  logic                 acc,
    input  logic signed [DW-1:0] din,
    output logic signed [DW-1:0] max_q
);

    always_ff @(posedge clk) begin
        if (load)
            max_q <= din;
        else if (acc && (din > max_q))
            max_q <= din;
    end

endmodule

// File: rtl/pool_sched.sv
// 2x2 stride-2 max-pool window scheduler over a synchronous-read feature buffer.
// Optional build macro POOL_RELU_EN clamps negative pooled values to zero.
module pool_sched
    import cnn_pkg::*;
#(
    parameter int N  = 16,
    parameter int M  = 5,
    parameter int DW = cnn_pkg::DW,
    localparam int W  = fmap_w(N, M),
    localparam int P  = pool_p(N, M),
    localparam int AW = addr_w(N, M),
    localparam int IW = idx_w(N, M)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic signed [DW-1:0] rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic [IW-1:0]        out_idx
);

    localparam int RW = (P > 1) ? $clog2(P) : 1;

    pool_state_t          state;
    logic [RW-1:0]        row;
    logic [RW-1:0]        col;
    logic [1:0]           phase;
    logic                 load;
    logic                 acc;
    logic signed [DW-1:0] max_q;
    logic signed [DW-1:0] win_val;

    function automatic logic signed [DW-1:0] rectify(input logic signed [DW-1:0] v);
`ifdef POOL_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Read data lags the strobe by one cycle, so phase p folds datum p-1.
    assign load = (state == ST_READ) && (phase == 2'd1);
    assign acc  = (state == ST_READ) && (phase >= 2'd2);

    win_max #(.DW(DW)) u_win_max (
        .clk   (clk),
        .load  (load),
        .acc   (acc),
        .din   (rd_data),
        .max_q (max_q)
    );

    assign win_val   = (rd_data > max_q) ? rd_data : max_q;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign rd_en     = (state == ST_READ);
    assign out_valid = (state == ST_EMIT);

    always_comb begin
        int a;
        a = 2 * int'(row) * W + 2 * int'(col) + (phase[1] ? W : 0) + int'(phase[0]);
        rd_addr = '0;
        if (state == ST_READ)
            rd_addr = AW'(a);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            row      <= '0;
            col      <= '0;
            phase    <= '0;
            out_data <= '0;
            out_idx  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_READ;
                        row   <= '0;
                        col   <= '0;
                        phase <= '0;
                    end
                end
                ST_READ: begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd3)
                        state <= ST_LAST;
                end
                ST_LAST: begin
                    out_data <= rectify(win_val);
                    out_idx  <= IW'(int'(row) * P + int'(col));
                    state    <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        phase <= '0;
                        if (col == RW'(P - 1)) begin
                            col <= '0;
                            if (row == RW'(P - 1)) begin
                                state <= ST_DONE;
                            end else begin
                                row   <= row + 1'b1;
                                state <= ST_READ;
                            end
                        end else begin
                            col   <= col + 1'b1;
                            state <= ST_READ;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
